// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths, address field slices and request record for the memory request queue
package mem_pkg;

    localparam int MEM_ADDR_WIDTH = 28;
    localparam int MEM_DATA_WIDTH = 32;
    localparam int MEM_READ_LAT   = 4;

    // Client address layout: {row[12:0], bank[1:0], column[12:0]}
    localparam int ROW_MSB  = 27;
    localparam int ROW_LSB  = 15;
    localparam int BANK_MSB = 14;
    localparam int BANK_LSB = 13;
    localparam int COL_MSB  = 12;
    localparam int COL_LSB  = 0;

    typedef struct packed {
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic                      we;
        logic [MEM_DATA_WIDTH-1:0] wdata;
    } mem_req_t;

    function automatic logic [MEM_ADDR_WIDTH-1:0] make_addr(
        input logic [ROW_MSB-ROW_LSB:0]   row,
        input logic [BANK_MSB-BANK_LSB:0] bank,
        input logic [COL_MSB-COL_LSB:0]   col
    );
        logic [MEM_ADDR_WIDTH-1:0] a;
        a = '0;
        a[ROW_MSB:ROW_LSB]   = row;
        a[BANK_MSB:BANK_LSB] = bank;
        a[COL_MSB:COL_LSB]   = col;
        return a;
    endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// rtl/mem_req_fifo.sv - parametrised request FIFO with registered occupancy
// Ports: CLK, RST (sync, active-high), push/wdata write side, pop/rdata read side
// (rdata is the head, valid whenever empty is low), full/empty status from occupancy.
module mem_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 61
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // Storage is not reset; empty/full come only from the occupancy count.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_request_queue.sv
// rtl/mem_request_queue.sv - client request queue feeding the command sequencer, with read-return tracking
// Ports: CLK, RST (sync, active-high); client side REQ_VALID/REQ_READY/REQ_ADDR/REQ_WE/REQ_WDATA;
// sequencer side ADDRESS_REQ/WE/DATA_W/DO_ACT/COMMAND_LATCHED; read return DATA_READ -> RD_VALID/RD_DATA;
// REFRESH_STROBE toggles every REFRESH_INTERVAL cycles when MEM_REFRESH_GEN_EN is defined, else tied 0.
module mem_request_queue
    import mem_pkg::*;
#(
    parameter int DEPTH            = 4,
    parameter int READ_LAT         = MEM_READ_LAT,
    parameter int REFRESH_INTERVAL = 1560
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      REQ_VALID,
    output logic                      REQ_READY,
    input  logic [MEM_ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic                      REQ_WE,
    input  logic [MEM_DATA_WIDTH-1:0] REQ_WDATA,
    output logic [MEM_ADDR_WIDTH-1:0] ADDRESS_REQ,
    output logic                      WE,
    output logic [MEM_DATA_WIDTH-1:0] DATA_W,
    output logic                      DO_ACT,
    input  logic                      COMMAND_LATCHED,
    input  logic [MEM_DATA_WIDTH-1:0] DATA_READ,
    output logic                      RD_VALID,
    output logic [MEM_DATA_WIDTH-1:0] RD_DATA,
    output logic                      REFRESH_STROBE
);

    mem_req_t push_entry;
    mem_req_t head;
    logic     push;
    logic     pop;
    logic     full;
    logic     empty;
    logic     out_of_reset;
    logic [READ_LAT-1:0] rd_pipe;

    // REQ_READY stays low during reset and rises on the first cycle after it.
    assign REQ_READY  = out_of_reset && !full;
    assign push       = REQ_VALID && REQ_READY;
    assign DO_ACT     = !empty;
    assign pop        = COMMAND_LATCHED && DO_ACT;
    assign push_entry = '{addr: REQ_ADDR, we: REQ_WE, wdata: REQ_WDATA};

    assign ADDRESS_REQ = head.addr;
    assign WE          = head.we;
    assign DATA_W      = head.wdata;

    mem_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(mem_req_t))
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // Each popped read launches a token; when it reaches the last stage DATA_READ
    // is the matching beat, so capture it and pulse RD_VALID.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_of_reset <= 1'b0;
            rd_pipe      <= '0;
            RD_VALID     <= 1'b0;
            RD_DATA      <= '0;
        end else begin
            out_of_reset <= 1'b1;
            rd_pipe[0]   <= pop && !head.we;
            for (int i = 1; i < READ_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
            RD_VALID <= rd_pipe[READ_LAT-1];
            if (rd_pipe[READ_LAT-1]) begin
                RD_DATA <= DATA_READ;
            end
        end
    end

`ifdef MEM_REFRESH_GEN_EN
    localparam int REF_W = (REFRESH_INTERVAL > 2) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_INTERVAL - 1);

    logic [REF_W-1:0] refresh_count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            refresh_count  <= '0;
            REFRESH_STROBE <= 1'b0;
        end else if (refresh_count == REF_LAST) begin
            refresh_count  <= '0;
            REFRESH_STROBE <= !REFRESH_STROBE;
        end else begin
            refresh_count  <= refresh_count + REF_W'(1);
        end
    end
`else
    // Refresh is supplied externally in this build.
    assign REFRESH_STROBE = 1'b0;
`endif

endmodule

// File: tb/tb_mem_request_queue.sv
// tb/tb_mem_request_queue.sv - directed self-checking bench for mem_request_queue
module tb_mem_request_queue;
    import mem_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic [27:0] REQ_ADDR;
    logic        REQ_WE;
    logic [31:0] REQ_WDATA;
    logic [27:0] ADDRESS_REQ;
    logic        WE;
    logic [31:0] DATA_W;
    logic        DO_ACT;
    logic        COMMAND_LATCHED;
    logic [31:0] DATA_READ;
    logic        RD_VALID;
    logic [31:0] RD_DATA;
    logic        REFRESH_STROBE;

    int errors = 0;
    int checks = 0;

    mem_request_queue #(
        .DEPTH            (4),
        .READ_LAT         (4),
        .REFRESH_INTERVAL (8)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .REQ_VALID       (REQ_VALID),
        .REQ_READY       (REQ_READY),
        .REQ_ADDR        (REQ_ADDR),
        .REQ_WE          (REQ_WE),
        .REQ_WDATA       (REQ_WDATA),
        .ADDRESS_REQ     (ADDRESS_REQ),
        .WE              (WE),
        .DATA_W          (DATA_W),
        .DO_ACT          (DO_ACT),
        .COMMAND_LATCHED (COMMAND_LATCHED),
        .DATA_READ       (DATA_READ),
        .RD_VALID        (RD_VALID),
        .RD_DATA         (RD_DATA),
        .REFRESH_STROBE  (REFRESH_STROBE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; REQ_VALID = 1'b0; REQ_ADDR = '0; REQ_WE = 1'b0; REQ_WDATA = '0;
        COMMAND_LATCHED = 1'b0; DATA_READ = '0;
        step(); step();
        checks++; if (DO_ACT !== 1'b0) begin errors++; $display("FAIL rst_do_act: got %b want 0", DO_ACT); end
        checks++; if (REQ_READY !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b want 0", REQ_READY); end
        checks++; if (RD_VALID !== 1'b0) begin errors++; $display("FAIL rst_rd_valid: got %b want 0", RD_VALID); end
        checks++; if (RD_DATA !== 32'h0) begin errors++; $display("FAIL rst_rd_data: got %h want 0", RD_DATA); end
        checks++; if (REFRESH_STROBE !== 1'b0) begin errors++; $display("FAIL rst_refresh: got %b want 0", REFRESH_STROBE); end
        RST = 1'b0;
        #1;
        checks++; if (REQ_READY !== 1'b0) begin errors++; $display("FAIL rst_ready_before_edge: got %b want 0", REQ_READY); end
        step();
        checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b want 1", REQ_READY); end
    endtask

    task automatic test_single_write();
        int rd_pulses;
        REQ_VALID = 1'b1; REQ_ADDR = 28'h000_0010; REQ_WE = 1'b1; REQ_WDATA = 32'h0ABC_D123;
        step();
        REQ_VALID = 1'b0;
        checks++; if (ADDRESS_REQ !== 28'h000_0010) begin errors++; $display("FAIL wr_addr: got %h want 0000010", ADDRESS_REQ); end
        checks++; if (WE !== 1'b1) begin errors++; $display("FAIL wr_we: got %b want 1", WE); end
        checks++; if (DATA_W !== 32'h0ABC_D123) begin errors++; $display("FAIL wr_data: got %h want 0abcd123", DATA_W); end
        for (int c = 0; c < 3; c++) begin
            checks++; if (DO_ACT !== 1'b1) begin errors++; $display("FAIL wr_do_act_wait%0d: got %b want 1", c, DO_ACT); end
            step();
        end
        COMMAND_LATCHED = 1'b1;
        #1;
        checks++; if (DO_ACT !== 1'b1) begin errors++; $display("FAIL wr_do_act_latch: got %b want 1", DO_ACT); end
        step();
        COMMAND_LATCHED = 1'b0;
        checks++; if (DO_ACT !== 1'b0) begin errors++; $display("FAIL wr_empty_after: got %b want 0", DO_ACT); end
        rd_pulses = 0;
        DATA_READ = 32'h5555_5555;
        for (int c = 0; c < 8; c++) begin
            if (RD_VALID === 1'b1) rd_pulses++;
            step();
        end
        checks++; if (rd_pulses !== 0) begin errors++; $display("FAIL wr_no_rd_valid: got %0d pulses want 0", rd_pulses); end
    endtask

    task automatic test_read_latency();
        int early;
        REQ_VALID = 1'b1; REQ_ADDR = make_addr(13'h246, 2'd2, 13'h0); REQ_WE = 1'b0; REQ_WDATA = 32'h0;
        step();
        REQ_VALID = 1'b0;
        checks++; if (ADDRESS_REQ !== 28'h123_4000) begin errors++; $display("FAIL rd_addr: got %h want 1234000", ADDRESS_REQ); end
        checks++; if (WE !== 1'b0) begin errors++; $display("FAIL rd_we: got %b want 0", WE); end
        COMMAND_LATCHED = 1'b1;           // cycle T
        DATA_READ = 32'h1111_1111;
        step();
        COMMAND_LATCHED = 1'b0;           // T+1
        early = 0;
        for (int c = 0; c < 3; c++) begin // T+1..T+3
            if (RD_VALID === 1'b1) early++;
            step();
        end
        DATA_READ = 32'hDEAD_BEEF;        // T+4
        if (RD_VALID === 1'b1) early++;
        checks++; if (early !== 0) begin errors++; $display("FAIL rd_early_valid: got %0d pulses want 0", early); end
        step();                           // T+5
        DATA_READ = 32'h2222_2222;
        checks++; if (RD_VALID !== 1'b1) begin errors++; $display("FAIL rd_valid_t5: got %b want 1", RD_VALID); end
        checks++; if (RD_DATA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data_t5: got %h want deadbeef", RD_DATA); end
        step();                           // T+6
        checks++; if (RD_VALID !== 1'b0) begin errors++; $display("FAIL rd_valid_t6: got %b want 0", RD_VALID); end
        checks++; if (RD_DATA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data_hold: got %h want deadbeef", RD_DATA); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            REQ_VALID = 1'b1; REQ_ADDR = 28'(32'h100 + i); REQ_WE = 1'b1; REQ_WDATA = 32'(i);
            #1;
            checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL full_ready_push%0d: got %b want 1", i, REQ_READY); end
            step();
        end
        checks++; if (REQ_READY !== 1'b0) begin errors++; $display("FAIL full_ready_low: got %b want 0", REQ_READY); end
        REQ_ADDR = 28'h0FF;               // 5th request, must be refused
        step();
        REQ_VALID = 1'b0;
        checks++; if (REQ_READY !== 1'b0) begin errors++; $display("FAIL full_ready_still_low: got %b want 0", REQ_READY); end
        checks++; if (ADDRESS_REQ !== 28'h100) begin errors++; $display("FAIL full_head: got %h want 0000100", ADDRESS_REQ); end
        COMMAND_LATCHED = 1'b1;
        step();
        COMMAND_LATCHED = 1'b0;
        checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop: got %b want 1", REQ_READY); end
        // Back-to-back drain: head advances every cycle with DO_ACT held high.
        COMMAND_LATCHED = 1'b1;
        for (int i = 1; i < 4; i++) begin
            checks++; if (DO_ACT !== 1'b1) begin errors++; $display("FAIL b2b_do_act%0d: got %b want 1", i, DO_ACT); end
            checks++; if (ADDRESS_REQ !== 28'(32'h100 + i)) begin errors++; $display("FAIL b2b_addr%0d: got %h want %h", i, ADDRESS_REQ, 28'(32'h100 + i)); end
            step();
        end
        checks++; if (DO_ACT !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b want 0", DO_ACT); end
        step();                           // latched while empty: ignored
        COMMAND_LATCHED = 1'b0;
        checks++; if (DO_ACT !== 1'b0) begin errors++; $display("FAIL ignore_latch_empty: got %b want 0", DO_ACT); end
    endtask

    task automatic test_push_pop_same_cycle();
        REQ_VALID = 1'b1; REQ_ADDR = 28'h200; REQ_WE = 1'b1; REQ_WDATA = 32'hA;
        step();
        REQ_ADDR = 28'h201; REQ_WDATA = 32'hB;
        COMMAND_LATCHED = 1'b1;
        step();
        REQ_VALID = 1'b0;
        COMMAND_LATCHED = 1'b0;
        checks++; if (DO_ACT !== 1'b1) begin errors++; $display("FAIL pp_do_act: got %b want 1", DO_ACT); end
        checks++; if (ADDRESS_REQ !== 28'h201) begin errors++; $display("FAIL pp_head: got %h want 0000201", ADDRESS_REQ); end
        COMMAND_LATCHED = 1'b1;
        step();
        COMMAND_LATCHED = 1'b0;
        checks++; if (DO_ACT !== 1'b0) begin errors++; $display("FAIL pp_drained: got %b want 0", DO_ACT); end
    endtask

    task automatic test_back_to_back_reads();
        REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_WDATA = 32'h0;
        REQ_ADDR = 28'h300;
        step();
        REQ_ADDR = 28'h304;
        step();
        REQ_VALID = 1'b0;
        COMMAND_LATCHED = 1'b1;           // T
        step();                           // T+1
        checks++; if (ADDRESS_REQ !== 28'h304) begin errors++; $display("FAIL b2br_second_head: got %h want 0000304", ADDRESS_REQ); end
        step();                           // T+2
        COMMAND_LATCHED = 1'b0;
        step();                           // T+3
        step();                           // T+4
        DATA_READ = 32'hCAFE_0001;
        step();                           // T+5
        DATA_READ = 32'hCAFE_0002;
        checks++; if (RD_VALID !== 1'b1) begin errors++; $display("FAIL b2br_valid_t5: got %b want 1", RD_VALID); end
        checks++; if (RD_DATA !== 32'hCAFE_0001) begin errors++; $display("FAIL b2br_data_t5: got %h want cafe0001", RD_DATA); end
        step();                           // T+6
        DATA_READ = 32'h3333_3333;
        checks++; if (RD_VALID !== 1'b1) begin errors++; $display("FAIL b2br_valid_t6: got %b want 1", RD_VALID); end
        checks++; if (RD_DATA !== 32'hCAFE_0002) begin errors++; $display("FAIL b2br_data_t6: got %h want cafe0002", RD_DATA); end
        step();                           // T+7
        checks++; if (RD_VALID !== 1'b0) begin errors++; $display("FAIL b2br_valid_t7: got %b want 0", RD_VALID); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        REQ_VALID = 1'b1; REQ_ADDR = 28'h400; REQ_WE = 1'b0;
        step();
        REQ_VALID = 1'b0;
        COMMAND_LATCHED = 1'b1;           // T
        step();
        COMMAND_LATCHED = 1'b0;           // T+1, queue another request
        REQ_VALID = 1'b1; REQ_ADDR = 28'h404;
        step();
        REQ_VALID = 1'b0;                 // T+2
        RST = 1'b1;
        step();
        RST = 1'b0;                       // T+3, released
        DATA_READ = 32'h7777_7777;
        #1;
        checks++; if (DO_ACT !== 1'b0) begin errors++; $display("FAIL mrst_do_act_release: got %b want 0", DO_ACT); end
        step();                           // T+4
        checks++; if (DO_ACT !== 1'b0) begin errors++; $display("FAIL mrst_do_act: got %b want 0", DO_ACT); end
        checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL mrst_req_ready: got %b want 1", REQ_READY); end
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            if (RD_VALID === 1'b1) pulses++;
            step();
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL mrst_no_rd_valid: got %0d pulses want 0", pulses); end
    endtask

    task automatic test_refresh();
        logic exp;
        RST = 1'b1;
        step();
        RST = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
`ifdef MEM_REFRESH_GEN_EN
            exp = ((k / 8) % 2) == 1;
`else
            exp = 1'b0;
`endif
            checks++; if (REFRESH_STROBE !== exp) begin errors++; $display("FAIL refresh_edge%0d: got %b want %b", k, REFRESH_STROBE, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_latency();
        test_full();
        test_push_pop_same_cycle();
        test_back_to_back_reads();
        test_reset_mid();
        test_refresh();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_request_queue.md
MEM_REQUEST_QUEUE -- requirements
Module: mem_request_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: request FIFO entries; power of two, 2..16.
REQ-002 SHALL have parameter READ_LAT, default 4: cycles from COMMAND_LATCHED sampled high to DATA_READ valid.
REQ-003 SHALL have parameter REFRESH_INTERVAL, default 1560: cycles between REFRESH_STROBE toggles.
REQ-004 SHALL have port CLK  in  1  the single clock; all logic on posedge CLK.
REQ-005 SHALL have port RST  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port REQ_VALID  in  1  client request present.
REQ-007 SHALL have port REQ_READY  out  1  queue accepts a request this cycle.
REQ-008 SHALL have port REQ_ADDR  in  28  client address {row[12:0], bank[1:0], column[12:0]}.
REQ-009 SHALL have port REQ_WE  in  1  1 = write, 0 = read.
REQ-010 SHALL have port REQ_WDATA  in  32  client write data.
REQ-011 SHALL have port ADDRESS_REQ  out  28  head address to the command sequencer.
REQ-012 SHALL have port WE  out  1  head write enable to the sequencer.
REQ-013 SHALL have port DATA_W  out  32  head write data to the DQ output stage.
REQ-014 SHALL have port DO_ACT  out  1  head entry valid, offered to the sequencer.
REQ-015 SHALL have port COMMAND_LATCHED  in  1  sequencer has accepted the head READ/WRTE.
REQ-016 SHALL have port DATA_READ  in  32  read data from the DQ capture stage.
REQ-017 SHALL have port RD_VALID  out  1  one-cycle pulse; RD_DATA valid.
REQ-018 SHALL have port RD_DATA  out  32  returned read data, held until next RD_VALID.
REQ-019 SHALL have port REFRESH_STROBE  out  1  toggle-type refresh request.

Function
REQ-020 SHALL push {REQ_ADDR, REQ_WE, REQ_WDATA} when REQ_VALID && REQ_READY; REQ_READY = !full, from registered occupancy.
REQ-021 SHALL drive ADDRESS_REQ/WE/DATA_W from the FIFO head combinationally, and DO_ACT = !empty.
REQ-022 SHALL pop the head on any cycle with COMMAND_LATCHED && DO_ACT; the next entry appears the following cycle with DO_ACT held high (back-to-back).
REQ-023 SHALL ignore COMMAND_LATCHED while DO_ACT is low.
REQ-024 SHALL allow push and pop in the same cycle: occupancy unchanged, order preserved; push while full is impossible because REQ_READY is low.
REQ-025 SHALL wrap read/write pointers modulo DEPTH, with occupancy 0..DEPTH.
REQ-026 SHALL, on each pop with WE=0, insert a token into a READ_LAT-stage shift pipeline; a token reaching the end loads RD_DATA <= DATA_READ and pulses RD_VALID next cycle.
REQ-027 SHALL support overlapping reads: one token per cycle, returned in issue order, without dropping any read.
REQ-028 SHALL NOT pulse RD_VALID for popped writes.

Reset
REQ-029 SHALL, while RST=1, empty the FIFO, clear the read pipeline, and set DO_ACT=0, REQ_READY=0, RD_VALID=0, RD_DATA=0, REFRESH_STROBE=0, refresh counter=0.
REQ-030 SHALL discard queued requests and in-flight read tokens on mid-operation reset, with no RD_VALID after RST deasserts for pre-reset reads.
REQ-031 SHALL raise REQ_READY the first cycle after RST deasserts.

Configuration
REQ-032 SHALL, with MEM_REFRESH_GEN_EN defined, count 0..REFRESH_INTERVAL-1 and toggle REFRESH_STROBE on wrap, independent of queue state.
REQ-033 SHALL, with MEM_REFRESH_GEN_EN undefined, omit the counter and tie REFRESH_STROBE to 0; an external source supplies refresh.

Structure
REQ-034 SHALL take address width (28), data width (32), field slices (row/bank/column) and default READ_LAT from shared package mem_pkg.
REQ-035 SHALL implement storage in one sub-module, mem_req_fifo (parametrised depth/width, push/pop/full/empty).

Verification
REQ-036 SHALL cover: single write 0x0ABC_D123 to addr 0x000_0010, COMMAND_LATCHED held low 3 cycles then pulsed -> DO_ACT high 4 cycles, FIFO empty after, no RD_VALID.
REQ-037 SHALL cover: read addr 0x123_4000 latched at cycle T, DATA_READ=0xDEAD_BEEF at T+4 -> RD_VALID at T+5, RD_DATA=0xDEAD_BEEF.
REQ-038 SHALL cover: 4 pushes with COMMAND_LATCHED low -> REQ_READY low after 4th; 5th REQ_VALID is not accepted; one pop -> REQ_READY high next cycle.
REQ-039 SHALL cover: reads latched on consecutive cycles T, T+1 -> RD_VALID at T+5 and T+6, data in order.
REQ-040 SHALL cover: RST pulsed at T+2 after read latched at T -> no RD_VALID; DO_ACT=0, REQ_READY=1 the cycle after release.
REQ-041 SHALL cover: MEM_REFRESH_GEN_EN with REFRESH_INTERVAL=8 -> REFRESH_STROBE toggles every 8 cycles from reset; undefined -> constant 0.
